// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory responder: stalls the pipeline while it runs a multi-cycle word access.
// Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned half/word accesses and adds a MISALIGN output.
module dmem_access_ctrl #(
  parameter int MM_ADDR_WIDTH = 30,
  parameter int RESP_TIMEOUT  = 255
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [2:0]               MEM_READ,
  input  logic [1:0]               MEM_WRITE,
  input  logic [31:0]              ADDRESS,
  input  logic [31:0]              WRITE_DATA,
  output logic [31:0]              DATA_READED,
  output logic                     BUSY_WAIT,
  output logic                     MM_READ,
  output logic                     MM_WRITE,
  output logic [MM_ADDR_WIDTH-1:0] MM_ADDRESS,
  output logic [31:0]              MM_WRITE_DATA,
  output logic [3:0]               MM_BYTE_EN,
  input  logic [31:0]              MM_READ_DATA,
  input  logic                     MM_BUSY_WAIT,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic                     MISALIGN,
`endif
  output logic                     TIMEOUT_ERR
);

  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         rd_op;
  logic               op_read;
  logic [1:0]         lane;
  logic               rd_valid, wr_valid, req_valid, misaligned;
  logic [31:0]        placed_data;
  logic [3:0]         placed_be;

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] b,
                                              input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  by;
    logic [15:0] hw;
    logic [31:0] res;
    shifted = w >> {b, 3'b000};
    by      = shifted[7:0];
    hw      = b[1] ? w[31:16] : w[15:0];
    case (op)
      3'b001:  res = {{24{by[7]}}, by};
      3'b010:  res = {{16{hw[15]}}, hw};
      3'b100:  res = {24'd0, by};
      3'b101:  res = {16'd0, hw};
      default: res = w;
    endcase
    return res;
  endfunction

  // A read request wins over a simultaneous write.
  always_comb begin
    rd_valid    = (MEM_READ >= 3'b001) && (MEM_READ <= 3'b101);
    wr_valid    = (MEM_WRITE != 2'b00);
    req_valid   = rd_valid || wr_valid;
    placed_data = 32'd0;
    placed_be   = 4'b0000;
    case (MEM_WRITE)
      2'b01: begin
        placed_data = {4{WRITE_DATA[7:0]}};
        placed_be   = 4'b0001 << ADDRESS[1:0];
      end
      2'b10: begin
        placed_data = {2{WRITE_DATA[15:0]}};
        placed_be   = ADDRESS[1] ? 4'b1100 : 4'b0011;
      end
      2'b11: begin
        placed_data = WRITE_DATA;
        placed_be   = 4'b1111;
      end
      default: ;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (rd_valid)
      misaligned = ((MEM_READ == 3'b010 || MEM_READ == 3'b101) && ADDRESS[0]) ||
                   ((MEM_READ == 3'b011) && (ADDRESS[1:0] != 2'b00));
    else
      misaligned = ((MEM_WRITE == 2'b10) && ADDRESS[0]) ||
                   ((MEM_WRITE == 2'b11) && (ADDRESS[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    BUSY_WAIT = 1'b0;
    case (state)
      IDLE:    BUSY_WAIT = req_valid;
      ACCESS:  BUSY_WAIT = 1'b1;
      default: BUSY_WAIT = 1'b0;
    endcase
    if (RESET) BUSY_WAIT = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_op         <= 3'b000;
      op_read       <= 1'b0;
      lane          <= 2'b00;
      DATA_READED   <= 32'd0;
      MM_READ       <= 1'b0;
      MM_WRITE      <= 1'b0;
      MM_ADDRESS    <= '0;
      MM_WRITE_DATA <= 32'd0;
      MM_BYTE_EN    <= 4'b0000;
      TIMEOUT_ERR   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      MISALIGN      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && misaligned) begin
            if (rd_valid) DATA_READED <= 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
            MISALIGN <= 1'b1;
`endif
            state <= DONE;
          end else if (req_valid) begin
            op_read       <= rd_valid;
            rd_op         <= MEM_READ;
            lane          <= ADDRESS[1:0];
            MM_ADDRESS    <= ADDRESS[MM_ADDR_WIDTH+1:2];
            MM_READ       <= rd_valid;
            MM_WRITE      <= !rd_valid;
            MM_WRITE_DATA <= rd_valid ? 32'd0 : placed_data;
            MM_BYTE_EN    <= rd_valid ? 4'b0000 : placed_be;
            cnt           <= '0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          // A response on the same edge the budget runs out still counts as a completion.
          if (!MM_BUSY_WAIT) begin
            if (op_read) DATA_READED <= load_extend(rd_op, lane, MM_READ_DATA);
            MM_READ  <= 1'b0;
            MM_WRITE <= 1'b0;
            state    <= DONE;
          end else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
            TIMEOUT_ERR <= 1'b1;
            DATA_READED <= 32'd0;
            MM_READ     <= 1'b0;
            MM_WRITE    <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
`ifdef DMEM_MISALIGN_TRAP_EN
          MISALIGN <= 1'b0;
`endif
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases from the handshake rules plus
// randomized loads/stores compared against a behavioural model of lane placement and extension.
module tb_dmem_access_ctrl;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  MEM_READ;
  logic [1:0]  MEM_WRITE;
  logic [31:0] ADDRESS, WRITE_DATA, DATA_READED, MM_WRITE_DATA, MM_READ_DATA;
  logic        BUSY_WAIT, MM_READ, MM_WRITE, MM_BUSY_WAIT, TIMEOUT_ERR;
  logic [29:0] MM_ADDRESS;
  logic [3:0]  MM_BYTE_EN;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        MISALIGN;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data = 32'd0;
  logic        exp_tmo  = 1'b0;
  logic [31:0] obs_wd;
  logic [3:0]  obs_be;
  logic [29:0] obs_addr;
  int          obs_busy;

  dmem_access_ctrl #(.MM_ADDR_WIDTH(30), .RESP_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .DATA_READED(DATA_READED),
    .BUSY_WAIT(BUSY_WAIT), .MM_READ(MM_READ), .MM_WRITE(MM_WRITE),
    .MM_ADDRESS(MM_ADDRESS), .MM_WRITE_DATA(MM_WRITE_DATA), .MM_BYTE_EN(MM_BYTE_EN),
    .MM_READ_DATA(MM_READ_DATA), .MM_BUSY_WAIT(MM_BUSY_WAIT),
`ifdef DMEM_MISALIGN_TRAP_EN
    .MISALIGN(MISALIGN),
`endif
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    int b;
    logic [7:0]  by;
    logic [15:0] hw;
    b  = int'(addr[1:0]);
    by = word[8*b +: 8];
    hw = addr[1] ? word[31:16] : word[15:0];
    case (op)
      3'd1:    return 32'($signed(by));
      3'd2:    return 32'($signed(hw));
      3'd4:    return {24'd0, by};
      3'd5:    return {16'd0, hw};
      default: return word;
    endcase
  endfunction

  function automatic logic model_misaligned(input logic [2:0] rd, input logic [1:0] wr,
                                            input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
    int size;
    size = 0;
    if (rd >= 3'd1 && rd <= 3'd5) size = (rd == 3'd3) ? 4 : ((rd == 3'd2 || rd == 3'd5) ? 2 : 1);
    else if (wr != 2'd0) size = (wr == 2'd3) ? 4 : ((wr == 2'd2) ? 2 : 1);
    return (size != 0) && ((addr % size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One full request: stall count, strobes, lane placement, result and the DONE/IDLE tail.
  task automatic run_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mw, input int waits);
    logic rdv, wrv, mis;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    int acc, exp_acc, sz, b;
    rdv = (rd >= 3'd1 && rd <= 3'd5);
    wrv = (wr != 2'd0);
    mis = model_misaligned(rd, wr, addr);
    b   = int'(addr[1:0]);
    sz  = (wr == 2'd3) ? 4 : ((wr == 2'd2) ? 2 : 1);
    e_wd = (sz == 4) ? wd : ((sz == 2) ? {wd[15:0], wd[15:0]} : {4{wd[7:0]}});
    e_be = (sz == 4) ? 4'hF : ((sz == 2) ? (4'h3 << (2 * (b / 2))) : (4'h1 << b));
    MEM_READ = rd; MEM_WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
    MM_READ_DATA = mw; MM_BUSY_WAIT = 1'b1;
    #1;
    checks++;
    if (!rdv && !wrv) begin
      if (BUSY_WAIT !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req: busy=%b want 0", BUSY_WAIT); end
      MEM_READ = 3'd0; MEM_WRITE = 2'd0;
      @(negedge CLK);
      return;
    end
    if (BUSY_WAIT !== 1'b1) begin errors++; $display("[TB] FAIL busy_cycle0: busy=%b want 1", BUSY_WAIT); end
    acc = 0;
    forever begin
      @(posedge CLK); #1;
      if (BUSY_WAIT !== 1'b1) break;
      acc++;
      if (acc == 1) begin
        obs_wd = MM_WRITE_DATA; obs_be = MM_BYTE_EN; obs_addr = MM_ADDRESS;
        checks++;
        if (MM_READ !== rdv || MM_WRITE !== !rdv || MM_ADDRESS !== addr[31:2] ||
            MM_BYTE_EN !== (rdv ? 4'h0 : e_be) || (!rdv && MM_WRITE_DATA !== e_wd)) begin
          errors++;
          $display("[TB] FAIL strobes: rd=%b wr=%b addr=%h be=%b wd=%h want rd=%b wr=%b addr=%h be=%b wd=%h",
                   MM_READ, MM_WRITE, MM_ADDRESS, MM_BYTE_EN, MM_WRITE_DATA,
                   rdv, !rdv, addr[31:2], rdv ? 4'h0 : e_be, e_wd);
        end
      end
      MM_BUSY_WAIT = (acc <= waits);
      if (acc > 300) begin
        errors++; $display("[TB] FAIL busy_bound: busy still high after %0d cycles want <=%0d", acc, TMO);
        break;
      end
    end
    exp_acc = mis ? 0 : ((waits < TMO) ? waits + 1 : TMO);
    if (mis) begin
      if (rdv) exp_data = 32'd0;
    end else if (waits >= TMO) begin
      exp_data = 32'd0; exp_tmo = 1'b1;
    end else if (rdv) begin
      exp_data = model_load(rd, addr, mw);
    end
    obs_busy = acc + 1;
    checks++;
    if (acc !== exp_acc) begin errors++; $display("[TB] FAIL access_cycles: got %0d want %0d", acc, exp_acc); end
    checks++;
    if (DATA_READED !== exp_data) begin errors++; $display("[TB] FAIL data_readed: got %h want %h", DATA_READED, exp_data); end
    checks++;
    if (TIMEOUT_ERR !== exp_tmo || MM_READ !== 1'b0 || MM_WRITE !== 1'b0) begin
      errors++; $display("[TB] FAIL done_state: tmo=%b rd=%b wr=%b want tmo=%b rd=0 wr=0", TIMEOUT_ERR, MM_READ, MM_WRITE, exp_tmo);
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++;
    if (MISALIGN !== mis) begin errors++; $display("[TB] FAIL misalign_pulse: got %b want %b", MISALIGN, mis); end
`endif
    MEM_READ = 3'd0; MEM_WRITE = 2'd0; MM_BUSY_WAIT = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (BUSY_WAIT !== 1'b0 || MM_READ !== 1'b0 || MM_WRITE !== 1'b0 || DATA_READED !== exp_data) begin
      errors++; $display("[TB] FAIL after_done: busy=%b rd=%b wr=%b data=%h want 0 0 0 %h",
                         BUSY_WAIT, MM_READ, MM_WRITE, DATA_READED, exp_data);
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++;
    if (MISALIGN !== 1'b0) begin errors++; $display("[TB] FAIL misalign_clear: got %b want 0", MISALIGN); end
`endif
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET = 1'b1; MEM_READ = 3'd3; MEM_WRITE = 2'd0; ADDRESS = 32'h10; WRITE_DATA = 32'h0;
    MM_READ_DATA = 32'h0; MM_BUSY_WAIT = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (BUSY_WAIT !== 1'b0 || MM_READ !== 1'b0 || MM_WRITE !== 1'b0 || DATA_READED !== 32'd0 ||
        MM_ADDRESS !== 30'd0 || MM_WRITE_DATA !== 32'd0 || MM_BYTE_EN !== 4'd0 || TIMEOUT_ERR !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state: busy=%b rd=%b wr=%b data=%h addr=%h wd=%h be=%b tmo=%b want all 0",
                         BUSY_WAIT, MM_READ, MM_WRITE, DATA_READED, MM_ADDRESS, MM_WRITE_DATA, MM_BYTE_EN, TIMEOUT_ERR);
    end
    MEM_READ = 3'd0;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_lw_basic;
    run_txn(3'd3, 2'd0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 0);
    checks++;
    if (obs_addr !== 30'h4 || obs_busy !== 2 || DATA_READED !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL lw_basic: addr=%h busy=%0d data=%h want 4 2 deadbeef", obs_addr, obs_busy, DATA_READED);
    end
  endtask

  task automatic test_load_extend;
    run_txn(3'd1, 2'd0, 32'h13, 32'h0, 32'h80FF_0102, 0);
    checks++;
    if (DATA_READED !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb: got %h want ffffff80", DATA_READED); end
    run_txn(3'd4, 2'd0, 32'h13, 32'h0, 32'h80FF_0102, 0);
    checks++;
    if (DATA_READED !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu: got %h want 00000080", DATA_READED); end
    run_txn(3'd2, 2'd0, 32'h12, 32'h0, 32'h80FF_0102, 0);
    checks++;
    if (DATA_READED !== 32'hFFFF80FF) begin errors++; $display("[TB] FAIL lh: got %h want ffff80ff", DATA_READED); end
  endtask

  task automatic test_store_lanes;
    run_txn(3'd0, 2'd1, 32'h06, 32'h12345678, 32'h0, 0);
    checks++;
    if (obs_be !== 4'b0100 || obs_wd !== 32'h78787878 || obs_addr !== 30'h1) begin
      errors++; $display("[TB] FAIL sb: be=%b wd=%h addr=%h want 0100 78787878 1", obs_be, obs_wd, obs_addr);
    end
    run_txn(3'd0, 2'd2, 32'h06, 32'h12345678, 32'h0, 0);
    checks++;
    if (obs_be !== 4'b1100 || obs_wd !== 32'h56785678) begin
      errors++; $display("[TB] FAIL sh: be=%b wd=%h want 1100 56785678", obs_be, obs_wd);
    end
    run_txn(3'd3, 2'd3, 32'h20, 32'h1, 32'hCAFE0001, 0);
  endtask

  task automatic test_wait_states;
    run_txn(3'd3, 2'd0, 32'h40, 32'h0, 32'h0BAD_F00D, 5);
    checks++;
    if (obs_busy !== 7) begin errors++; $display("[TB] FAIL wait5_busy: got %0d want 7", obs_busy); end
  endtask

  task automatic test_reset_mid_access;
    MEM_READ = 3'd0; MEM_WRITE = 2'd3; ADDRESS = 32'h80; WRITE_DATA = 32'hA5A5A5A5; MM_BUSY_WAIT = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (MM_WRITE !== 1'b1) begin errors++; $display("[TB] FAIL sw_started: wr=%b want 1", MM_WRITE); end
    #2 RESET = 1'b1;
    #1;
    exp_data = 32'd0; exp_tmo = 1'b0;
    checks++;
    if (MM_WRITE !== 1'b0 || BUSY_WAIT !== 1'b0 || DATA_READED !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_mid: wr=%b busy=%b data=%h want 0 0 0", MM_WRITE, BUSY_WAIT, DATA_READED);
    end
    MEM_WRITE = 2'd0; MM_BUSY_WAIT = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    run_txn(3'd3, 2'd0, 32'h84, 32'h0, 32'h1357_9BDF, 1);
  endtask

  task automatic test_timeout;
    run_txn(3'd3, 2'd0, 32'h100, 32'h0, 32'h7777_7777, 1000);
    checks++;
    if (TIMEOUT_ERR !== 1'b1 || DATA_READED !== 32'd0 || obs_busy !== TMO + 1) begin
      errors++; $display("[TB] FAIL timeout: tmo=%b data=%h busy=%0d want 1 0 %0d", TIMEOUT_ERR, DATA_READED, obs_busy, TMO + 1);
    end
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_misalign;
    run_txn(3'd3, 2'd0, 32'h02, 32'h0, 32'h1111_2222, 0);
    checks++;
    if (obs_busy !== 1) begin errors++; $display("[TB] FAIL misalign_lw: busy=%0d want 1", obs_busy); end
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_txn(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset;
    test_lw_basic;
    test_load_extend;
    test_store_lanes;
    test_wait_states;
    test_reset_mid_access;
    test_timeout;
`ifdef DMEM_MISALIGN_TRAP_EN
    test_misalign;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
